// File: rtl/data_bus_seq.sv
// data_bus_seq: registered multi-source bus mux with sticky conflict tracking.
// Optional macro DATA_BUS_PARITY_EN adds a registered even-parity output.
module data_bus_seq #(
    parameter int REG_COUNT = 16,
    parameter int WIDTH     = 12,
    localparam int IDXW     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [REG_COUNT-1:0]       read_en,
    input  logic [REG_COUNT*WIDTH-1:0] src_data,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           dataout,
    output logic                       bus_valid,
    output logic [IDXW-1:0]            src_idx,
    output logic                       conflict,
    output logic [15:0]                xfer_cnt,
`ifdef DATA_BUS_PARITY_EN
    output logic                       parity,
`endif
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             valid_q, valid_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             conflict_q, conflict_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             any_req;
    logic             multi_req;
    logic [IDXW-1:0]  sel_idx;
    logic [WIDTH-1:0] sel_data;
    logic             found;

    // Request decode: lowest set read_en bit wins the bus
    always_comb begin
        any_req   = |read_en;
        multi_req = |(read_en & (read_en - {{(REG_COUNT-1){1'b0}}, 1'b1}));
        sel_idx   = '0;
        sel_data  = '0;
        found     = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (read_en[i] && !found) begin
                sel_idx  = IDXW'(i);
                sel_data = src_data[i*WIDTH +: WIDTH];
                found    = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: multi-hot forces ERR from anywhere, ERR exits only on err_clr
    always_comb begin
        state_d = state_q;
        if (multi_req) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE:  state_d = any_req ? S_DRIVE : S_IDLE;
                S_DRIVE: state_d = any_req ? S_DRIVE : S_HOLD;
                S_HOLD:  state_d = any_req ? S_DRIVE : S_HOLD;
                S_ERR: begin
                    if (err_clr) state_d = any_req ? S_DRIVE : S_HOLD;
                    else         state_d = S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output next values: bus data, index, valid, counter and sticky conflict
    always_comb begin
        dataout_d  = any_req ? sel_data : dataout_q;
        idx_d      = any_req ? sel_idx : idx_q;
        valid_d    = any_req;
        cnt_d      = cnt_q + {15'd0, any_req};
        conflict_d = conflict_q;
        if (multi_req)
            conflict_d = 1'b1;
        else if (err_clr && (state_q == S_ERR))
            conflict_d = 1'b0;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout_q  <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            dataout_q  <= dataout_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef DATA_BUS_PARITY_EN
    logic parity_q;

    // Parity tracks dataout in the same register stage
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ^dataout_d;
    end

    assign parity = parity_q;
`endif

    assign dataout   = dataout_q;
    assign bus_valid = valid_q;
    assign src_idx   = idx_q;
    assign conflict  = conflict_q;
    assign xfer_cnt  = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_data_bus_seq.sv
// tb_data_bus_seq: directed self-checking bench for data_bus_seq.
// Each step compares the full output bundle against hand-computed values.
module tb_data_bus_seq;

    localparam int RC = 16;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [RC-1:0] read_en;
    logic [RC*W-1:0] src_data;
    logic          err_clr;
    logic [W-1:0]  dataout;
    logic          bus_valid;
    logic [3:0]    src_idx;
    logic          conflict;
    logic [15:0]   xfer_cnt;
    logic [1:0]    state;
`ifdef DATA_BUS_PARITY_EN
    logic          parity;
`endif

    int total = 0;
    int bad   = 0;

    // bundle: dataout(12) valid(1) idx(4) conflict(1) cnt(16) state(2)
    logic [35:0] obs;
    logic [35:0] exp_v;

    data_bus_seq #(.REG_COUNT(RC), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .read_en   (read_en),
        .src_data  (src_data),
        .err_clr   (err_clr),
        .dataout   (dataout),
        .bus_valid (bus_valid),
        .src_idx   (src_idx),
        .conflict  (conflict),
        .xfer_cnt  (xfer_cnt),
`ifdef DATA_BUS_PARITY_EN
        .parity    (parity),
`endif
        .state     (state)
    );

    always #5 clk = ~clk;

    assign obs = {dataout, bus_valid, src_idx, conflict, xfer_cnt, state};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; read_en = '0; err_clr = 1'b0; src_data = '0;
        step(); step();
        reset = 1'b0;
        step();
        exp_v = {12'h000, 1'b0, 4'd0, 1'b0, 16'd0, 2'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_single();
        set_src(0, 12'hE08);
        read_en = 16'h0001;
        step();
        exp_v = {12'hE08, 1'b1, 4'd0, 1'b0, 16'd1, 2'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL single: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_hold();
        read_en = 16'h0000;
        set_src(0, 12'h123);
        step();
        exp_v = {12'hE08, 1'b0, 4'd0, 1'b0, 16'd1, 2'd2};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL hold: got %h want %h", obs, exp_v);
        end
        step();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL hold2: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_conflict();
        set_src(4, 12'hE0F);
        set_src(15, 12'h188);
        read_en = 16'h8010;
        step();
        exp_v = {12'hE0F, 1'b1, 4'd4, 1'b1, 16'd2, 2'd3};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL conflict: got %h want %h", obs, exp_v);
        end
        read_en = 16'h0000;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_v = {12'hE0F, 1'b0, 4'd4, 1'b0, 16'd2, 2'd2};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL conflict_clr: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_err_paths();
        set_src(0, 12'h0A1);
        set_src(1, 12'h1B2);
        set_src(2, 12'h2C3);
        set_src(3, 12'h3D4);
        // err_clr racing a multi-hot: set wins
        read_en = 16'h0003; err_clr = 1'b1;
        step();
        exp_v = {12'h0A1, 1'b1, 4'd0, 1'b1, 16'd3, 2'd3};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL race_set: got %h want %h", obs, exp_v);
        end
        // err_clr with one-hot transfer: leave to DRIVE
        read_en = 16'h0004;
        step();
        err_clr = 1'b0;
        exp_v = {12'h2C3, 1'b1, 4'd2, 1'b0, 16'd4, 2'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL clr_drive: got %h want %h", obs, exp_v);
        end
        read_en = 16'h0006;
        step();
        exp_v = {12'h1B2, 1'b1, 4'd1, 1'b1, 16'd5, 2'd3};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reenter_err: got %h want %h", obs, exp_v);
        end
        // one-hot transfer inside ERR without err_clr stays in ERR
        read_en = 16'h0008;
        step();
        exp_v = {12'h3D4, 1'b1, 4'd3, 1'b1, 16'd6, 2'd3};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL err_xfer: got %h want %h", obs, exp_v);
        end
        read_en = 16'h0000; err_clr = 1'b1;
        step();
        exp_v = {12'h3D4, 1'b0, 4'd3, 1'b0, 16'd6, 2'd2};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL clr_hold: got %h want %h", obs, exp_v);
        end
        // err_clr outside ERR: no effect; src change without read_en ignored
        set_src(3, 12'h777);
        step();
        err_clr = 1'b0;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL clr_outside: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_err();
        set_src(8, 12'h888);
        set_src(9, 12'h999);
        read_en = 16'h0300;
        step();
        exp_v = {12'h888, 1'b1, 4'd8, 1'b1, 16'd7, 2'd3};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL pre_rst_err: got %h want %h", obs, exp_v);
        end
        reset = 1'b1; read_en = 16'hFFFF; err_clr = 1'b1;
        step();
        exp_v = {12'h000, 1'b0, 4'd0, 1'b0, 16'd0, 2'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL rst_mid_err: got %h want %h", obs, exp_v);
        end
        reset = 1'b0; err_clr = 1'b0;
        set_src(0, 12'h5A5);
        read_en = 16'h0001;
        step();
        exp_v = {12'h5A5, 1'b1, 4'd0, 1'b0, 16'd1, 2'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL first_after_rst: got %h want %h", obs, exp_v);
        end
    endtask

`ifdef DATA_BUS_PARITY_EN
    task automatic test_parity();
        set_src(6, 12'h001);
        read_en = 16'h0040;
        step();
        total++;
        if (parity !== 1'b1) begin
            bad++;
            $display("FAIL parity_001: got %b want 1", parity);
        end
        set_src(6, 12'h003);
        step();
        total++;
        if (parity !== 1'b0) begin
            bad++;
            $display("FAIL parity_003: got %b want 0", parity);
        end
        set_src(6, 12'h007);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; read_en = '0;
        total++;
        if ({parity, obs} !== 37'd0) begin
            bad++;
            $display("FAIL parity_rst: got %h want 0", {parity, obs});
        end
    endtask
`endif

    task automatic test_wrap();
        reset = 1'b1; read_en = '0; err_clr = 1'b0;
        step();
        reset = 1'b0;
        set_src(5, 12'hABC);
        read_en = 16'h0020;
        for (int n = 0; n < 65535; n++) begin
            @(posedge clk);
        end
        #1;
        exp_v = {12'hABC, 1'b1, 4'd5, 1'b0, 16'hFFFF, 2'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL preload: got %h want %h", obs, exp_v);
        end
        step();
        exp_v = {12'hABC, 1'b1, 4'd5, 1'b0, 16'h0000, 2'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL wrap: got %h want %h", obs, exp_v);
        end
        read_en = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_conflict();
        test_err_paths();
        test_reset_mid_err();
`ifdef DATA_BUS_PARITY_EN
        test_parity();
`endif
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
